// File: rtl/mem_bus_pkg.sv
// Shared types and IO map for the CPU byte-bus responder.
// Exports byte_t, IO_SEL (bus_a[17:16]), IO_DATA and IO_STAT.
package mem_bus_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0]  IO_SEL  = 2'b11;
  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; count spans 0..DEPTH.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout,
//        full, empty, count.
module byte_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  byte_t       din,
  input  logic        pop,
  output byte_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  byte_t       mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // Wrap bit disambiguates full from empty when indices match.
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/mem_bus_responder.sv
// Byte RAM + console IO target for the CPU memory bus.
// Ports: clk_in, rst_in (sync, active-low), rdy_in, bus_en/a/wr/
//   wdata/rdata, tx_valid/data/ready, rx_valid/data/ready,
//   io_full, bus_err. Macro MEM_BUS_RESP_ERR_EN enables bus_err.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        bus_en,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        io_full,
  output logic        bus_err
);

  localparam int RAM_DEPTH = 2**RAM_AW;
  localparam int CW = $clog2(TX_DEPTH) + 1;

  byte_t ram [RAM_DEPTH];

  logic          act;
  logic          is_io;
  logic          is_ram;
  logic          is_data;
  logic          is_stat;
  logic          rd_ram;
  logic          rd_data;
  logic          rd_stat;
  logic          ram_we;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  byte_t         tx_head;

  // Reset wins over rdy_in; rdy_in low freezes everything.
  assign act = rst_in & rdy_in & bus_en;

  assign is_io   = (bus_a[17:16] == IO_SEL);
  assign is_ram  = ~is_io &
                   (64'(bus_a) < 64'(RAM_DEPTH));
  assign is_data = is_io & (bus_a == IO_DATA);
  assign is_stat = is_io & (bus_a == IO_STAT);

  assign rd_ram  = ~bus_wr & is_ram;
  assign rd_data = ~bus_wr & is_data;
  assign rd_stat = ~bus_wr & is_stat;

  assign ram_we   = act & bus_wr & is_ram;
  assign tx_push  = act & bus_wr & is_data & ~tx_full;
  assign tx_pop   = rst_in & rdy_in & ~tx_empty & tx_ready;
  assign rx_ready = act & rd_data & rx_valid;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[bus_a[RAM_AW-1:0]] <= bus_wdata;
  end

  // Writes, unknown IO and out-of-range reads all return 0.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bus_rdata <= '0;
    end else if (act) begin
      unique case (1'b1)
        rd_ram:  bus_rdata <= ram[bus_a[RAM_AW-1:0]];
        rd_data: bus_rdata <= rx_valid ? rx_data : 8'h00;
        rd_stat: bus_rdata <= {6'b0, rx_valid, io_full};
        default: bus_rdata <= '0;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (tx_push),
    .din   (bus_wdata),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_head;
  assign io_full  = (tx_count == CW'(TX_DEPTH));

`ifdef MEM_BUS_RESP_ERR_EN
  logic err_hit;

  assign err_hit = act &
                   ((~is_io & ~is_ram) |
                    (bus_wr & is_io & ~is_data));

  always_ff @(posedge clk_in) begin
    if (!rst_in)      bus_err <= 1'b0;
    else if (err_hit) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed steps
// plus random traffic against a queue/array reference model.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        bus_en;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        io_full;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mram [logic [31:0]];
  logic [7:0] txq [$];
  logic [7:0] m_rdata;
  logic       m_err;

  always #5 clk_in = ~clk_in;

  mem_bus_responder dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .bus_en    (bus_en),
    .bus_a     (bus_a),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .io_full   (io_full),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h",
             tag, obs, exp);
    end
  endtask

  // Reference: one bus cycle from the map rules, on pre-edge values.
  task automatic model_update();
    logic full;
    logic pop;
    logic push;
    if (!rst_in) begin
      m_rdata = 8'h00;
      txq.delete();
      m_err = 1'b0;
    end else if (rdy_in) begin
      full = (txq.size() == 8);
      pop  = (txq.size() > 0) && tx_ready;
      push = 1'b0;
      if (bus_en) begin
        if (bus_a[17:16] == 2'b11) begin
          if (bus_wr) begin
            m_rdata = 8'h00;
            if (bus_a == 32'h30000) push = !full;
            else m_err = 1'b1;
          end else if (bus_a == 32'h30000) begin
            m_rdata = rx_valid ? rx_data : 8'h00;
          end else if (bus_a == 32'h30004) begin
            m_rdata = {6'b0, rx_valid, full};
          end else begin
            m_rdata = 8'h00;
          end
        end else if (bus_a < 32'h20000) begin
          if (bus_wr) begin
            mram[bus_a] = bus_wdata;
            m_rdata = 8'h00;
          end else begin
            m_rdata = mram[bus_a];
          end
        end else begin
          m_rdata = 8'h00;
          m_err = 1'b1;
        end
      end
      if (pop) void'(txq.pop_front());
      if (push) txq.push_back(bus_wdata);
    end
  endtask

  task automatic step(input string tag);
    logic exp_rxr;
    logic exp_err;
    #1;
    exp_rxr = rst_in && rdy_in && bus_en && !bus_wr &&
              (bus_a == 32'h30000) && rx_valid;
    chk({tag, "/rx_ready"}, {7'b0, rx_ready}, {7'b0, exp_rxr});
    model_update();
    @(posedge clk_in);
    #1;
`ifdef MEM_BUS_RESP_ERR_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    chk({tag, "/rdata"}, bus_rdata, m_rdata);
    chk({tag, "/tx_valid"}, {7'b0, tx_valid},
        {7'b0, txq.size() > 0});
    if (txq.size() > 0)
      chk({tag, "/tx_data"}, tx_data, txq[0]);
    chk({tag, "/io_full"}, {7'b0, io_full},
        {7'b0, txq.size() == 8});
    chk({tag, "/bus_err"}, {7'b0, bus_err}, {7'b0, exp_err});
  endtask

  task automatic bus(input logic en, input logic wr,
                     input logic [31:0] a, input logic [7:0] wd,
                     input string tag);
    bus_en    = en;
    bus_wr    = wr;
    bus_a     = a;
    bus_wdata = wd;
    step(tag);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rst_in = 1'b0; rdy_in = 1'b1;
    bus_en = 1'b0; bus_wr = 1'b0;
    bus_a = '0; bus_wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_rdata = 8'h00; m_err = 1'b0;
    @(posedge clk_in); #1;

    bus(0, 0, 0, 0, "rst0");
    bus(0, 0, 0, 0, "rst1");
    rst_in = 1'b1;

    bus(1, 1, 32'h100, 8'hA5, "ramw");
    bus(1, 0, 32'h100, 8'h00, "ramr");
    for (int i = 1; i < 4; i++)
      bus(1, 1, 32'h100 + i, 8'h10 * i[7:0] + 8'h3, "ramw4");
    for (int i = 0; i < 4; i++)
      bus(1, 0, 32'h100 + i, 8'h00, "ramr4");
    bus(0, 0, 0, 0, "hold");

    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      bus(1, 1, 32'h30000, i[7:0], "txfill");
    bus(1, 0, 32'h30004, 0, "statfull");
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) bus(0, 0, 0, 0, "txdrain");

    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      bus(1, 1, 32'h30000, 8'h20 + i[7:0], "wrapfill");
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) bus(0, 0, 0, 0, "wrappop");
    for (int i = 0; i < 6; i++)
      bus(1, 1, 32'h30000, 8'h40 + i[7:0], "wrapboth");
    for (int i = 0; i < 4; i++) bus(0, 0, 0, 0, "wrapdrain");

    rx_valid = 1'b1; rx_data = 8'h41;
    bus(1, 0, 32'h30000, 0, "rxrd");
    bus(1, 0, 32'h30004, 0, "rxstat");
    rx_valid = 1'b0;
    bus(1, 0, 32'h30000, 0, "rxnone");
    bus(1, 0, 32'h30008, 0, "iounk");

    rdy_in = 1'b0; rx_valid = 1'b1;
    bus(1, 1, 32'h30000, 8'h77, "rdy0tx");
    bus(1, 1, 32'h100, 8'h5A, "rdy0ram");
    bus(1, 0, 32'h30000, 0, "rdy0rx");
    rdy_in = 1'b1; rx_valid = 1'b0;
    bus(1, 0, 32'h100, 0, "rdy1ram");

    bus(1, 0, 32'h20000, 0, "oorrd");
    bus(1, 0, 32'h101, 0, "sticky");
    bus(1, 1, 32'h30004, 8'hFF, "statwr");

    for (int i = 0; i < 16; i++)
      bus(1, 1, 32'h100 + i, 8'($urandom), "pool");
    bus(1, 1, 32'h1FFFF, 8'($urandom), "pooltop");

    for (int n = 0; n < 500; n++) begin
      rst_in   = ($urandom_range(0, 63) != 0);
      rdy_in   = ($urandom_range(0, 7) != 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2, 3: a = 32'h100 + $urandom_range(0, 15);
        4:          a = 32'h1FFFF;
        5, 6, 7:    a = 32'h30000;
        8:          a = 32'h30004;
        9:          a = 32'h30008;
        default:    a = ($urandom_range(0, 1) == 1) ?
                        32'h2FFFF : 32'h4000_0000;
      endcase
      bus($urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          a, 8'($urandom), "rand");
    end

    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0;
    bus(1, 1, 32'h30000, 8'h99, "prerst");
    rst_in = 1'b0;
    bus(1, 0, 32'h100, 0, "midrst");
    rst_in = 1'b1;
    bus(0, 0, 0, 0, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
